// File: rtl/connect_n_win_scanner.sv
`timescale 1ns/1ps
// Sequential Connect-N detector: snapshots a ROWS x COLS board and scans one anchor per clock.
// Optional draw output is built only when CONNECT_DRAW_DETECT_EN is defined.

module connect_n_dir_chk #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4,
  parameter int DR      = 1,
  parameter int DC      = 0,
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic [2*ROWS*COLS-1:0] i_board,
  input  logic [RW-1:0]          i_row,
  input  logic [CW-1:0]          i_col,
  input  logic [1:0]             i_cell,
  output logic                   o_match
);
  int w_rr, w_cc;

  // Any step off the board kills the match, so no column wrap-around is possible.
  always_comb begin
    o_match = 1'b1;
    w_rr    = 0;
    w_cc    = 0;
    for (int k = 0; k < WIN_LEN; k++) begin
      w_rr = int'(i_row) + k * DR;
      w_cc = int'(i_col) + k * DC;
      if (w_rr < 0 || w_rr >= ROWS || w_cc < 0 || w_cc >= COLS)
        o_match = 1'b0;
      else if (i_board[2*(w_rr*COLS+w_cc) +: 2] != i_cell)
        o_match = 1'b0;
    end
  end
endmodule

module connect_n_win_scanner #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4,
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int NB     = 2 * ROWS * COLS
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [NB-1:0] i_board,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_win,
  output logic [1:0]    o_winner,
  output logic [3:0]    o_dir,
  output logic [RW-1:0] o_win_row,
  output logic [CW-1:0] o_win_col,
  output logic          o_draw
);
  localparam int MAXD = (ROWS > COLS) ? ROWS : COLS;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  generate
    if (WIN_LEN < 2 || WIN_LEN > MAXD) begin : g_bad_param
      $error("connect_n_win_scanner: WIN_LEN must be in 2..max(ROWS,COLS)");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;
  state_t r_state, w_next;

  logic [NB-1:0] r_board;
  logic [RW-1:0] r_row, r_win_row;
  logic [CW-1:0] r_col, r_win_col;
  logic          r_win;
  logic [1:0]    r_winner;
  logic [3:0]    r_dir;

  logic [1:0]    w_cell;
  logic [3:0]    w_dir;
  logic          w_qual, w_hit, w_last;
  int            w_aidx;

  assign w_aidx = int'(r_row) * COLS + int'(r_col);
  assign w_cell = r_board[2*w_aidx +: 2];
  assign w_qual = (w_cell == 2'b01) || (w_cell == 2'b10);
  assign w_hit  = w_qual && (|w_dir);
  assign w_last = (r_row == LAST_ROW) && (r_col == LAST_COL);

  // dir bit order {ldiag, rdiag, hor, ver}
  generate
    for (genvar g = 0; g < 4; g++) begin : g_dir
      localparam int DR = (g == 1) ? 0 : 1;
      localparam int DC = (g == 0) ? 0 : ((g == 3) ? -1 : 1);
      connect_n_dir_chk #(
        .ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN), .DR(DR), .DC(DC)
      ) u_chk (
        .i_board(r_board),
        .i_row  (r_row),
        .i_col  (r_col),
        .i_cell (w_cell),
        .o_match(w_dir[g])
      );
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_SCAN;
      S_SCAN:  if (w_hit || w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_board   <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_win     <= 1'b0;
      r_winner  <= 2'b00;
      r_dir     <= 4'b0000;
      r_win_row <= '0;
      r_win_col <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_board   <= i_board;
          r_row     <= '0;
          r_col     <= '0;
          r_win     <= 1'b0;
          r_winner  <= 2'b00;
          r_dir     <= 4'b0000;
          r_win_row <= '0;
          r_win_col <= '0;
        end
        S_SCAN: begin
          if (w_hit) begin
            r_win     <= 1'b1;
            r_winner  <= w_cell;
            r_dir     <= w_dir;
            r_win_row <= r_row;
            r_win_col <= r_col;
          end else if (!w_last) begin
            if (r_col == LAST_COL) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CONNECT_DRAW_DETECT_EN
  logic r_draw;
  logic w_top_full;

  always_comb begin
    w_top_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (r_board[2*((ROWS-1)*COLS+c) +: 2] != 2'b01 &&
          r_board[2*((ROWS-1)*COLS+c) +: 2] != 2'b10)
        w_top_full = 1'b0;
    end
  end

  // Draw is decided only when the scan runs out of anchors without a win.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                             r_draw <= 1'b0;
    else if (r_state == S_IDLE && i_start) r_draw <= 1'b0;
    else if (r_state == S_SCAN && !w_hit && w_last) r_draw <= w_top_full;
  end

  assign o_draw = r_draw;
`else
  assign o_draw = 1'b0;
`endif

  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);
  assign o_win     = r_win;
  assign o_winner  = r_winner;
  assign o_dir     = r_dir;
  assign o_win_row = r_win_row;
  assign o_win_col = r_win_col;
endmodule

// File: tb/tb_connect_n_win_scanner.sv
`timescale 1ns/1ps
// Scoreboard bench: directed boards for a 6x7/4 scanner and a 5x5/5 scanner.
module tb_connect_n_win_scanner;
  localparam int R  = 6, C = 7, NB = 2*R*C;
  localparam int NB5 = 50;
`ifdef CONNECT_DRAW_DETECT_EN
  localparam int DRAWX = 1;
`else
  localparam int DRAWX = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start_a = 1'b0, busy_a, done_a, win_a, draw_a;
  logic [NB-1:0] board_a = '0;
  logic [1:0]    winner_a;
  logic [3:0]    dir_a;
  logic [2:0]    row_a, col_a;

  logic           start_b = 1'b0, busy_b, done_b, win_b, draw_b;
  logic [NB5-1:0] board_b = '0;
  logic [1:0]     winner_b;
  logic [3:0]     dir_b;
  logic [2:0]     row_b, col_b;

  connect_n_win_scanner #(.ROWS(6), .COLS(7), .WIN_LEN(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_board(board_a),
    .o_busy(busy_a), .o_done(done_a), .o_win(win_a), .o_winner(winner_a),
    .o_dir(dir_a), .o_win_row(row_a), .o_win_col(col_a), .o_draw(draw_a));

  connect_n_win_scanner #(.ROWS(5), .COLS(5), .WIN_LEN(5)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_board(board_b),
    .o_busy(busy_b), .o_done(done_b), .o_win(win_b), .o_winner(winner_b),
    .o_dir(dir_b), .o_win_row(row_b), .o_win_col(col_b), .o_draw(draw_b));

  typedef struct {
    int t0; int lat; int win; int winner; int dir; int row; int col; int draw;
  } exp_t;

  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int cyc = 0;
  int checks = 0, failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done_a) begin
      if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_latency", cyc - ea.t0, ea.lat);
        chk("a_win",     int'(win_a),    ea.win);
        chk("a_winner",  int'(winner_a), ea.winner);
        chk("a_dir",     int'(dir_a),    ea.dir);
        chk("a_row",     int'(row_a),    ea.row);
        chk("a_col",     int'(col_a),    ea.col);
        chk("a_draw",    int'(draw_a),   ea.draw);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done_b) begin
      if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_latency", cyc - eb.t0, eb.lat);
        chk("b_win",     int'(win_b),    eb.win);
        chk("b_winner",  int'(winner_b), eb.winner);
        chk("b_dir",     int'(dir_b),    eb.dir);
        chk("b_row",     int'(row_b),    eb.row);
        chk("b_col",     int'(col_b),    eb.col);
      end
    end
  end

  function automatic logic [NB-1:0] put(input logic [NB-1:0] b, input int r, input int c,
                                        input logic [1:0] v);
    b[2*(r*C+c) +: 2] = v;
    return b;
  endfunction

  task automatic issue_a(input logic [NB-1:0] b, input int lat, input int win, input int winner,
                         input int dir, input int row, input int col, input int draw);
    exp_t e;
    @(negedge clk);
    board_a = b;
    start_a = 1'b1;
    e = '{t0: cyc, lat: lat, win: win, winner: winner, dir: dir, row: row, col: col, draw: draw};
    qa.push_back(e);
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  task automatic wait_a();
    for (int i = 0; i < 100 && qa.size() != 0; i++) @(posedge clk);
    if (qa.size() != 0) begin
      chk("a_done_timeout", 1, 0);
      qa.delete();
    end
  endtask

  task automatic run_a(input logic [NB-1:0] b, input int lat, input int win, input int winner,
                       input int dir, input int row, input int col, input int draw);
    issue_a(b, lat, win, winner, dir, row, col, draw);
    wait_a();
  endtask

  task automatic run_b(input logic [NB5-1:0] b, input int lat, input int win, input int winner,
                       input int dir, input int row, input int col);
    exp_t e;
    @(negedge clk);
    board_b = b;
    start_b = 1'b1;
    e = '{t0: cyc, lat: lat, win: win, winner: winner, dir: dir, row: row, col: col, draw: 0};
    qb.push_back(e);
    @(posedge clk);
    #1 start_b = 1'b0;
    for (int i = 0; i < 100 && qb.size() != 0; i++) @(posedge clk);
    if (qb.size() != 0) begin
      chk("b_done_timeout", 1, 0);
      qb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NB-1:0]  b;
    logic [NB5-1:0] b5;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_win",  int'(win_a),  0);
    chk("rst_outs", int'({winner_a, dir_a, row_a, col_a, draw_a}), 0);
    chk("rst_b",    int'({busy_b, done_b, win_b, winner_b, dir_b, row_b, col_b, draw_b}), 0);
    @(negedge clk) rst = 1'b0;

    // vertical P1 in column 0
    b = '0;
    for (int k = 0; k < 4; k++) b = put(b, k, 0, 2'b01);
    run_a(b, 2, 1, 1, 4'b0001, 0, 0, 0);

    // horizontal P2 on row 2, cols 3..6
    b = '0;
    for (int k = 0; k < 4; k++) b = put(b, 2, 3 + k, 2'b10);
    run_a(b, 19, 1, 2, 4'b0010, 2, 3, 0);

    // left diagonal P1 from (0,6)
    b = '0;
    for (int k = 0; k < 4; k++) b = put(b, k, 6 - k, 2'b01);
    run_a(b, 8, 1, 1, 4'b1000, 0, 6, 0);

    // right diagonal P2 from (1,1)
    b = '0;
    for (int k = 0; k < 4; k++) b = put(b, 1 + k, 1 + k, 2'b10);
    run_a(b, 10, 1, 2, 4'b0100, 1, 1, 0);

    // empty board: full scan
    run_a('0, 43, 0, 0, 0, 0, 0, 0);

    // full board with no run of four
    b = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        b = put(b, r, c, (((c / 2) + r) % 2 == 0) ? 2'b01 : 2'b10);
    run_a(b, 43, 0, 0, 0, 0, 0, DRAWX);

    // run of five reports its lowest anchor
    b = '0;
    for (int k = 1; k <= 5; k++) b = put(b, 0, k, 2'b01);
    run_a(b, 3, 1, 1, 4'b0010, 0, 1, 0);

    // consecutive indices across a row edge are not a run
    b = '0;
    b = put(b, 0, 5, 2'b01); b = put(b, 0, 6, 2'b01);
    b = put(b, 1, 0, 2'b01); b = put(b, 1, 1, 2'b01);
    run_a(b, 43, 0, 0, 0, 0, 0, 0);

    // ver and hor from the same anchor
    b = '0;
    for (int k = 0; k < 4; k++) begin
      b = put(b, 0, k, 2'b10);
      b = put(b, k, 0, 2'b10);
    end
    run_a(b, 2, 1, 2, 4'b0011, 0, 0, 0);

    // both players win: first anchor in scan order is P2 at (1,2)
    b = '0;
    for (int k = 0; k < 4; k++) begin
      b = put(b, 3, k, 2'b01);
      b = put(b, 1, 2 + k, 2'b10);
    end
    run_a(b, 11, 1, 2, 4'b0010, 1, 2, 0);

    // code 11 counts as empty
    b = '0;
    for (int k = 0; k < 4; k++) b = put(b, 0, k, 2'b11);
    run_a(b, 43, 0, 0, 0, 0, 0, 0);

    // vertical reaching the top row in the last column
    b = '0;
    for (int k = 2; k < 6; k++) b = put(b, k, 6, 2'b01);
    run_a(b, 22, 1, 1, 4'b0001, 2, 6, 0);

    // start pulse and board change mid-scan are ignored
    b = '0;
    for (int k = 0; k < 4; k++) b = put(b, 2, 3 + k, 2'b10);
    issue_a(b, 19, 1, 2, 4'b0010, 2, 3, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", int'(busy_a), 1);
    board_a = '0;
    for (int k = 0; k < 4; k++) board_a = put(board_a, k, 0, 2'b01);
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    wait_a();
    repeat (50) @(posedge clk);

    // reset while evaluating anchor 10
    @(negedge clk);
    board_a = '0;
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_busy", int'(busy_a), 0);
    chk("rst_mid_done", int'(done_a), 0);
    chk("rst_mid_outs", int'({win_a, winner_a, dir_a, row_a, col_a, draw_a}), 0);
    @(negedge clk) rst = 1'b0;
    b = '0;
    for (int k = 0; k < 4; k++) b = put(b, 1 + k, 1 + k, 2'b10);
    run_a(b, 10, 1, 2, 4'b0100, 1, 1, 0);

    // 5x5 board, WIN_LEN 5
    b5 = '0;
    for (int k = 0; k < 5; k++) b5[2*(k*5+k) +: 2] = 2'b10;
    run_b(b5, 2, 1, 2, 4'b0100, 0, 0);
    b5 = '0;
    for (int k = 0; k < 5; k++) b5[2*(k*5+4) +: 2] = 2'b01;
    run_b(b5, 6, 1, 1, 4'b0001, 0, 4);
    b5 = '0;
    for (int k = 0; k < 4; k++) b5[2*(k*5+k) +: 2] = 2'b01;
    run_b(b5, 26, 0, 0, 0, 0, 0);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
